// File: rtl/ps2_pkg.sv
// Shared constants and frame-level state type for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam logic [7:0]  PS2_BRK        = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic {
        IDLE,
        RECV
    } frame_state_t;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Keyboard pins in, decoded scancode event out.
interface ps2_kbd_rx_if;

    logic [1:0] kbd;
    logic [7:0] code;
    logic       valid;
    logic       released;
    logic       extended;
    logic       err;
    logic       busy;

    modport master (
        input  kbd,
        output code, valid, released, extended, err, busy
    );

    modport slave (
        output kbd,
        input  code, valid, released, extended, err, busy
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, clock glitch filter and 11-bit frame receiver with timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] kbd,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        sync1, sync2;
    logic              filt, filt_d;
    logic [FCNT_W-1:0] fcnt;
    logic              sample, ps2_data;

    frame_state_t      state, state_n;
    logic [3:0]        bitcnt, bitcnt_n;
    logic [7:0]        sh, sh_n;
    logic              par, par_n;
    logic [TCNT_W-1:0] tcnt, tcnt_n;
    logic              strobe_n, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            sync1  <= kbd;
            sync2  <= sync1;
            filt_d <= filt;
            if (sync2[0] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FCNT_W'(FILTER_LEN - 1)) begin
                filt <= ~filt;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign sample   = filt_d & ~filt;
    assign ps2_data = sync2[1];

    // A sample event is checked before the timeout so it wins a same-cycle tie.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        sh_n     = sh;
        par_n    = par;
        tcnt_n   = tcnt;
        strobe_n = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            IDLE: begin
                tcnt_n = '0;
                if (sample && !ps2_data) begin
                    state_n  = RECV;
                    bitcnt_n = 4'd1;
                end
            end
            RECV: begin
                if (sample) begin
                    tcnt_n   = '0;
                    bitcnt_n = bitcnt + 4'd1;
                    if (bitcnt <= 4'd8) begin
                        sh_n = {ps2_data, sh[7:1]};
                    end else if (bitcnt == 4'(PS2_FRAME_BITS - 2)) begin
                        par_n = ps2_data;
                    end else begin
                        state_n  = IDLE;
                        bitcnt_n = '0;
                        if ((^{sh, par}) && ps2_data) strobe_n = 1'b1;
                        else                          err_n    = 1'b1;
                    end
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    state_n  = IDLE;
                    bitcnt_n = '0;
                    err_n    = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bitcnt      <= '0;
            sh          <= '0;
            par         <= 1'b0;
            tcnt        <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            bitcnt      <= bitcnt_n;
            sh          <= sh_n;
            par         <= par_n;
            tcnt        <= tcnt_n;
            byte_strobe <= strobe_n;
            frame_err   <= err_n;
        end
    end

    assign rx_byte = sh;
    assign busy    = (state == RECV);

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 set-2 scancode decoder: strips E0/F0 prefixes into extended/released flags.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 5000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_kbd_rx_if.master bus
);

    logic [7:0] rx_byte;
    logic       byte_strobe, frame_err, frame_busy;

    logic [7:0] code_q;
    logic       valid_q, released_q, extended_q, err_q;
    logic       ext_pend, brk_pend;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_frame (
        .clk         (clk),
        .rst         (rst),
        .kbd         (bus.kbd),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .frame_err   (frame_err),
        .busy        (frame_busy)
    );

    // Prefixes accumulate in either order until a non-prefix byte consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q     <= '0;
            valid_q    <= 1'b0;
            released_q <= 1'b0;
            extended_q <= 1'b0;
            err_q      <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= frame_err;
            if (frame_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_strobe) begin
                if (rx_byte == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (rx_byte == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    code_q     <= rx_byte;
                    released_q <= brk_pend;
                    extended_q <= ext_pend;
                    valid_q    <= 1'b1;
                    ext_pend   <= 1'b0;
                    brk_pend   <= 1'b0;
                end
            end
        end
    end

    assign bus.code     = code_q;
    assign bus.valid    = valid_q;
    assign bus.released = released_q;
    assign bus.extended = extended_q;
    assign bus.err      = err_q;
    assign bus.busy     = frame_busy;

endmodule
